gpio_pad_ctrl: RTL



---
 rtl/gpio_pad_pkg.sv | 22 ++
 rtl/gpio_sync.sv | 23 ++
 rtl/gpio_pad_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gpio_pad_pkg.sv
// Shared constants for the GPIO pad controller: register word addresses
// and default pad counts.
package gpio_pad_pkg;

    localparam int NUM_INPUT_PADS_DEF = 6;
    localparam int NUM_BIDIR_PADS_DEF = 16;
    localparam int NUM_PADS_DEF       = NUM_INPUT_PADS_DEF + NUM_BIDIR_PADS_DEF;

    localparam logic [3:0] ADDR_OUT     = 4'd0;
    localparam logic [3:0] ADDR_OE      = 4'd1;
    localparam logic [3:0] ADDR_IE      = 4'd2;
    localparam logic [3:0] ADDR_PU      = 4'd3;
    localparam logic [3:0] ADDR_PD      = 4'd4;
    localparam logic [3:0] ADDR_CS      = 4'd5;
    localparam logic [3:0] ADDR_SL      = 4'd6;
    localparam logic [3:0] ADDR_IN      = 4'd7;
    localparam logic [3:0] ADDR_RISE_EN = 4'd8;
    localparam logic [3:0] ADDR_FALL_EN = 4'd9;
    localparam logic [3:0] ADDR_STATUS  = 4'd10;
    localparam logic [3:0] ADDR_IPULL   = 4'd11;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser bank for asynchronous pad inputs.
module gpio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Register-programmable pad controller: drives bidir/input pad controls,
// synchronises pad inputs and latches enabled edges into sticky status.
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int NUM_INPUT_PADS = NUM_INPUT_PADS_DEF,
    parameter int NUM_BIDIR_PADS = NUM_BIDIR_PADS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [3:0]                req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    input  logic [NUM_INPUT_PADS-1:0] input_in,
    output logic [NUM_INPUT_PADS-1:0] input_pu,
    output logic [NUM_INPUT_PADS-1:0] input_pd,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
    output logic [NUM_BIDIR_PADS-1:0] bidir_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic                      irq
);

    localparam int NUM_PADS = NUM_INPUT_PADS + NUM_BIDIR_PADS;

    if (NUM_PADS > 32) begin : g_too_many_pads
        $error("gpio_pad_ctrl: NUM_INPUT_PADS + NUM_BIDIR_PADS must not exceed 32");
    end

    logic [NUM_BIDIR_PADS-1:0] out_r, oe_r, ie_r, pu_r, pd_r, cs_r, sl_r;
    logic [NUM_INPUT_PADS-1:0] ipu_r, ipd_r;
    logic [NUM_PADS-1:0]       rise_en, fall_en, status;
    logic [NUM_PADS-1:0]       sync, hist, edge_set, clr;
    logic                      irq_r, rsp_valid_r;
    logic [31:0]               rsp_rdata_r, rdata_mux;
    logic                      accept, unused_wdata;

    gpio_sync #(.WIDTH(NUM_PADS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({input_in, bidir_in}),
        .q     (sync)
    );

    assign req_ready    = ~rsp_valid_r | rsp_ready;
    assign accept       = req_valid & req_ready;
    assign unused_wdata = ^req_wdata;

    assign edge_set = (sync & ~hist & rise_en) | (~sync & hist & fall_en);
    assign clr      = (accept && req_we && req_addr == ADDR_STATUS) ? req_wdata[NUM_PADS-1:0] : '0;

    always_comb begin
        rdata_mux = '0;
        case (req_addr)
            ADDR_OUT:     rdata_mux[NUM_BIDIR_PADS-1:0] = out_r;
            ADDR_OE:      rdata_mux[NUM_BIDIR_PADS-1:0] = oe_r;
            ADDR_IE:      rdata_mux[NUM_BIDIR_PADS-1:0] = ie_r;
            ADDR_PU:      rdata_mux[NUM_BIDIR_PADS-1:0] = pu_r;
            ADDR_PD:      rdata_mux[NUM_BIDIR_PADS-1:0] = pd_r;
            ADDR_CS:      rdata_mux[NUM_BIDIR_PADS-1:0] = cs_r;
            ADDR_SL:      rdata_mux[NUM_BIDIR_PADS-1:0] = sl_r;
            ADDR_IN:      rdata_mux[NUM_PADS-1:0]       = sync;
            ADDR_RISE_EN: rdata_mux[NUM_PADS-1:0]       = rise_en;
            ADDR_FALL_EN: rdata_mux[NUM_PADS-1:0]       = fall_en;
            ADDR_STATUS:  rdata_mux[NUM_PADS-1:0]       = status;
            ADDR_IPULL: begin
                rdata_mux[NUM_INPUT_PADS-1:0]   = ipu_r;
                rdata_mux[8 +: NUM_INPUT_PADS]  = ipd_r;
            end
            default:      rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            oe_r        <= '0;
            ie_r        <= '1;
            pu_r        <= '0;
            pd_r        <= '0;
            cs_r        <= '0;
            sl_r        <= '0;
            ipu_r       <= '0;
            ipd_r       <= '0;
            rise_en     <= '0;
            fall_en     <= '0;
            status      <= '0;
            hist        <= '0;
            irq_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            hist   <= sync;
            // a new edge beats a same-cycle write-1-to-clear
            status <= (status & ~clr) | edge_set;
            irq_r  <= |status;

            if (accept) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= req_we ? 32'h0 : rdata_mux;
            end else if (rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end

            if (accept && req_we) begin
                case (req_addr)
                    ADDR_OUT:     out_r   <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_OE:      oe_r    <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_IE:      ie_r    <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_PU:      pu_r    <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_PD:      pd_r    <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_CS:      cs_r    <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_SL:      sl_r    <= req_wdata[NUM_BIDIR_PADS-1:0];
                    ADDR_RISE_EN: rise_en <= req_wdata[NUM_PADS-1:0];
                    ADDR_FALL_EN: fall_en <= req_wdata[NUM_PADS-1:0];
                    ADDR_IPULL: begin
                        ipu_r <= req_wdata[NUM_INPUT_PADS-1:0];
                        ipd_r <= req_wdata[8 +: NUM_INPUT_PADS];
                    end
                    default: ;
                endcase
            end
        end
    end

    // pull-up takes priority when both pulls are requested
    assign bidir_out = out_r;
    assign bidir_oe  = oe_r;
    assign bidir_ie  = ie_r;
    assign bidir_cs  = cs_r;
    assign bidir_sl  = sl_r;
    assign bidir_pu  = pu_r;
    assign bidir_pd  = pd_r & ~pu_r;
    assign input_pu  = ipu_r;
    assign input_pd  = ipd_r & ~ipu_r;
    assign irq       = irq_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule
